floo_axis_vc_rx: RTL and testbench

Receive end of the credit-based virtual-channel NoC bridge. It takes the AXI-Stream beats produced by the bridge transmitter on the far side and demultiplexes them by header bit into independent request and response flit buffers. It drains those buffers towards the local chimney's req/rsp flit inputs. For every flit drained it accumulates credits and returns them in coalesced credit messages, so the far-side transmitter never overflows a buffer and one stalled channel never blocks the other.

---
 rtl/floo_axis_vc_rx_pkg.sv | 27 ++
 rtl/floo_axis_vc_rx_fifo.sv | 68 ++++++
 rtl/floo_axis_vc_rx.sv | 189 ++++++++++++++++++
 tb/tb_floo_axis_vc_rx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_axis_vc_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : floo_axis_vc_rx_pkg
// Brief    : Shared types and helpers for the virtual-channel bridge receiver.
// Revision : 1.0 - initial release
// ============================================================================
package floo_axis_vc_rx_pkg;

  // Virtual channel identifiers; the value doubles as the stream header bit.
  typedef enum logic [0:0] {
    VcReq = 1'b0,
    VcRsp = 1'b1
  } vc_chan_e;

  // Credit return state machine encoding.
  typedef enum logic [0:0] {
    CrIdle  = 1'b0,
    CrOffer = 1'b1
  } cr_state_e;

  // Widest flit payload; the header bit sits directly above it.
  function automatic int unsigned find_max_channel(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/floo_axis_vc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : floo_axis_vc_rx_fifo
// Brief    : Registered-output flit buffer, no fall-through. Simultaneous push
//            and pop are supported; pushes while full are ignored here and the
//            caller accounts for them.
// Revision : 1.0 - initial release
// ============================================================================
module floo_axis_vc_rx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned c_cnt_w = $clog2(Depth + 1);

  logic [Width-1:0]   r_mem [Depth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == c_cnt_w'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at Depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(Depth - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(Depth - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/floo_axis_vc_rx.sv
`default_nettype none
// ============================================================================
// Module   : floo_axis_vc_rx
// Brief    : Receive side of the credit-based virtual-channel bridge. Splits
//            incoming stream beats into request/response buffers, drains them
//            to the chimney and returns coalesced credits round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module floo_axis_vc_rx
  import floo_axis_vc_rx_pkg::*;
#(
  parameter int unsigned NumCredits    = 8,
  parameter int unsigned ReqDataWidth  = 64,
  parameter int unsigned RspDataWidth  = 48,
  parameter int unsigned AxisDataWidth = 72,
  parameter int unsigned CntWidth      = $clog2(NumCredits + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     axis_tvalid_i,
  input  logic [AxisDataWidth-1:0] axis_tdata_i,
  output logic                     axis_tready_o,
  output logic                     req_valid_o,
  output logic [ReqDataWidth-1:0]  req_data_o,
  input  logic                     req_ready_i,
  output logic                     rsp_valid_o,
  output logic [RspDataWidth-1:0]  rsp_data_o,
  input  logic                     rsp_ready_i,
  output logic                     credit_valid_o,
  output logic                     credit_chan_o,
  output logic [CntWidth-1:0]      credit_cnt_o,
  input  logic                     credit_ready_i,
  output logic                     overflow_o
);

  localparam int unsigned c_hdr_bit = find_max_channel(ReqDataWidth, RspDataWidth);

  logic                r_tready;
  logic                r_overflow;
  logic                w_beat;
  logic                w_hdr;
  logic                w_req_full, w_req_empty, w_req_push;
  logic                w_rsp_full, w_rsp_empty, w_rsp_push;
  logic [1:0]          w_pop;
  logic                w_unused_tdata;

  cr_state_e           r_state, w_state_d;
  logic                r_rr_ptr;
  vc_chan_e            r_chan;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_pending [2];
  logic [CntWidth-1:0] w_pending_d [2];
  logic [CntWidth:0]   w_sum [2];
  logic                w_sat;
  logic                w_any;
  logic                w_grant;
  logic                w_grant_idx;

  assign w_unused_tdata = ^axis_tdata_i;

  // Stream is always ready once out of reset; the credit loop guarantees space.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_tready <= 1'b0;
    else         r_tready <= 1'b1;
  end

  assign axis_tready_o = r_tready;
  assign w_beat        = axis_tvalid_i & r_tready;
  assign w_hdr         = axis_tdata_i[c_hdr_bit];
  assign w_req_push    = w_beat & ~w_hdr & ~w_req_full;
  assign w_rsp_push    = w_beat &  w_hdr & ~w_rsp_full;

  // Sticky overflow: a beat targeted a full buffer (pop in the same edge does not rescue it).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else if (w_beat && (w_hdr ? w_rsp_full : w_req_full)) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;

  floo_axis_vc_rx_fifo #(
    .Depth (NumCredits),
    .Width (ReqDataWidth)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_req_push),
    .data_i  (axis_tdata_i[ReqDataWidth-1:0]),
    .pop_i   (req_ready_i),
    .data_o  (req_data_o),
    .full_o  (w_req_full),
    .empty_o (w_req_empty)
  );

  floo_axis_vc_rx_fifo #(
    .Depth (NumCredits),
    .Width (RspDataWidth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_rsp_push),
    .data_i  (axis_tdata_i[RspDataWidth-1:0]),
    .pop_i   (rsp_ready_i),
    .data_o  (rsp_data_o),
    .full_o  (w_rsp_full),
    .empty_o (w_rsp_empty)
  );

  assign req_valid_o = ~w_req_empty;
  assign rsp_valid_o = ~w_rsp_empty;
  assign w_pop       = {rsp_valid_o & rsp_ready_i, req_valid_o & req_ready_i};

  // Next-state and grant: pick the pointed channel if it has credits, else the other.
  always_comb begin
    w_state_d   = r_state;
    w_grant     = 1'b0;
    w_any       = (r_pending[0] != '0) || (r_pending[1] != '0);
    w_grant_idx = (r_pending[r_rr_ptr] != '0) ? r_rr_ptr : ~r_rr_ptr;
    case (r_state)
      CrIdle: begin
        if (w_any) begin
          w_state_d = CrOffer;
          w_grant   = 1'b1;
        end
      end
      CrOffer: begin
        if (credit_ready_i) begin
          if (w_any) w_grant   = 1'b1;
          else       w_state_d = CrIdle;
        end
      end
      default: w_state_d = CrIdle;
    endcase
  end

  // Pending credit update: granted channel restarts from this edge's pop, others accumulate.
  always_comb begin
    w_sat = 1'b0;
    for (int c = 0; c < 2; c++) begin
      w_sum[c] = {1'b0, r_pending[c]} + (CntWidth + 1)'(w_pop[c]);
      if (w_grant && (w_grant_idx == c[0])) begin
        w_sum[c] = (CntWidth + 1)'(w_pop[c]);
      end
      if (w_sum[c] > (CntWidth + 1)'(NumCredits)) begin
        w_sat          = 1'b1;
        w_pending_d[c] = CntWidth'(NumCredits);
      end else begin
        w_pending_d[c] = w_sum[c][CntWidth-1:0];
      end
    end
  end

  // Credit state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= CrIdle;
    else         r_state <= w_state_d;
  end

  // Pending counters, offered message and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pending[0] <= '0;
      r_pending[1] <= '0;
      r_rr_ptr     <= 1'b0;
      r_chan       <= VcReq;
      r_cnt        <= '0;
    end else begin
      r_pending[0] <= w_pending_d[0];
      r_pending[1] <= w_pending_d[1];
      if (w_grant) begin
        r_chan   <= vc_chan_e'(w_grant_idx);
        r_cnt    <= r_pending[w_grant_idx];
        r_rr_ptr <= ~w_grant_idx;
      end
    end
  end

  assign credit_valid_o = (r_state == CrOffer);
  assign credit_chan_o  = r_chan;
  assign credit_cnt_o   = r_cnt;

  // More drained flits than buffer slots means the far side broke the credit protocol.
  a_no_credit_sat : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_sat);

endmodule
`default_nettype wire

// File: tb/tb_floo_axis_vc_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_floo_axis_vc_rx
// Brief    : Self-checking bench for floo_axis_vc_rx with a queue-based model
//            of the buffers and a credit-counting far-side transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_floo_axis_vc_rx;

  localparam int NC = 8;
  localparam int RQW = 64;
  localparam int RSW = 48;
  localparam int AXW = 72;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic axis_tvalid_i;
  logic [AXW-1:0] axis_tdata_i;
  logic axis_tready_o;
  logic req_valid_o;
  logic [RQW-1:0] req_data_o;
  logic req_ready_i;
  logic rsp_valid_o;
  logic [RSW-1:0] rsp_data_o;
  logic rsp_ready_i;
  logic credit_valid_o;
  logic credit_chan_o;
  logic [CW-1:0] credit_cnt_o;
  logic credit_ready_i;
  logic overflow_o;

  always #5 clk = ~clk;

  floo_axis_vc_rx dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .axis_tvalid_i  (axis_tvalid_i),
    .axis_tdata_i   (axis_tdata_i),
    .axis_tready_o  (axis_tready_o),
    .req_valid_o    (req_valid_o),
    .req_data_o     (req_data_o),
    .req_ready_i    (req_ready_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_ready_i    (rsp_ready_i),
    .credit_valid_o (credit_valid_o),
    .credit_chan_o  (credit_chan_o),
    .credit_cnt_o   (credit_cnt_o),
    .credit_ready_i (credit_ready_i),
    .overflow_o     (overflow_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [RQW-1:0] q_req[$];
  logic [RSW-1:0] q_rsp[$];
  bit exp_ovf;
  int pops[2];
  int returned[2];
  int tx_cred[2];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: capture pre-edge handshakes, advance the model, check outputs.
  task automatic tick();
    bit in_rst, beat, rf, sf, cf, hold, hchan;
    logic [AXW-1:0] td;
    logic [CW-1:0] hcnt;
    logic cchan;
    logic [CW-1:0] ccnt;
    in_rst = !rst_ni;
    beat = axis_tvalid_i && axis_tready_o;
    td = axis_tdata_i;
    rf = req_valid_o && req_ready_i;
    sf = rsp_valid_o && rsp_ready_i;
    cf = credit_valid_o && credit_ready_i;
    hold = credit_valid_o && !credit_ready_i;
    hchan = credit_chan_o;
    hcnt = credit_cnt_o;
    cchan = credit_chan_o;
    ccnt = credit_cnt_o;
    @(posedge clk);
    #1;
    if (in_rst) begin
      q_req.delete();
      q_rsp.delete();
      exp_ovf = 0;
      pops = '{0, 0};
      returned = '{0, 0};
      tx_cred = '{NC, NC};
      chk("rst_tready", axis_tready_o, 0);
      chk("rst_credit_valid", credit_valid_o, 0);
    end else begin
      if (beat) begin
        if (td[64] == 1'b0) begin
          if (q_req.size() == NC) exp_ovf = 1;
          else q_req.push_back(td[RQW-1:0]);
        end else begin
          if (q_rsp.size() == NC) exp_ovf = 1;
          else q_rsp.push_back(td[RSW-1:0]);
        end
      end
      if (rf) begin void'(q_req.pop_front()); pops[0]++; end
      if (sf) begin void'(q_rsp.pop_front()); pops[1]++; end
      if (cf) begin
        chk("credit_cnt_range", (ccnt >= 1) && (ccnt <= NC), 1);
        returned[cchan] += int'(ccnt);
        tx_cred[cchan] += int'(ccnt);
      end
      if (hold) begin
        chk("credit_hold_valid", credit_valid_o, 1);
        chk("credit_hold_chan", credit_chan_o, hchan);
        chk("credit_hold_cnt", credit_cnt_o, hcnt);
      end
    end
    chk("req_valid", req_valid_o, q_req.size() != 0);
    if (q_req.size() != 0) chk("req_data", req_data_o, q_req[0]);
    chk("rsp_valid", rsp_valid_o, q_rsp.size() != 0);
    if (q_rsp.size() != 0) chk("rsp_data", rsp_data_o, q_rsp[0]);
    chk("overflow", overflow_o, exp_ovf);
    chk("ret_le_pops_req", returned[0] <= pops[0], 1);
    chk("ret_le_pops_rsp", returned[1] <= pops[1], 1);
  endtask

  // Present one beat for one cycle; upper unused bits carry noise.
  task automatic send(input bit c, input logic [63:0] payload, input bit noise);
    logic [95:0] r;
    logic [AXW-1:0] td;
    r = {$urandom(), $urandom(), $urandom()};
    td = noise ? r[AXW-1:0] : '0;
    if (c == 1'b0) td[RQW-1:0] = payload;
    else td[RSW-1:0] = payload[RSW-1:0];
    td[64] = c;
    axis_tvalid_i = 1'b1;
    axis_tdata_i = td;
    tx_cred[c]--;
    tick();
    axis_tvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    int p0;
    int sent;
    int cyc;
    bit c;
    rst_ni = 1'b0;
    axis_tvalid_i = 1'b0;
    axis_tdata_i = '0;
    req_ready_i = 1'b0;
    rsp_ready_i = 1'b0;
    credit_ready_i = 1'b0;
    q_req.delete();
    q_rsp.delete();
    exp_ovf = 0;
    pops = '{0, 0};
    returned = '{0, 0};
    tx_cred = '{NC, NC};

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("tready_after_rst", axis_tready_o, 1);

    // Step 1: three request beats, in-order delivery, 3 credits on req
    req_ready_i = 1'b1;
    credit_ready_i = 1'b1;
    send(0, 64'h11, 0);
    chk("t1_first_valid", req_valid_o, 1);
    chk("t1_first_data", req_data_o, 64'h11);
    send(0, 64'h22, 0);
    chk("t1_second_data", req_data_o, 64'h22);
    send(0, 64'h33, 0);
    chk("t1_third_data", req_data_o, 64'h33);
    repeat (8) tick();
    chk("t1_credits_req", returned[0], 3);
    chk("t1_credits_rsp", returned[1], 0);

    // Step 2: credits held back, single cnt=1 then coalesced cnt=7
    credit_ready_i = 1'b0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send(1, 64'(i * 32'h101), 0);
    repeat (4) tick();
    chk("t2_offer_valid", credit_valid_o, 1);
    chk("t2_offer_chan", credit_chan_o, 1);
    chk("t2_offer_cnt", credit_cnt_o, 1);
    repeat (3) tick();
    credit_ready_i = 1'b1;
    tick();
    chk("t2_next_valid", credit_valid_o, 1);
    chk("t2_next_chan", credit_chan_o, 1);
    chk("t2_next_cnt", credit_cnt_o, 7);
    tick();
    chk("t2_idle", credit_valid_o, 0);
    chk("t2_credits_rsp", returned[1], 8);

    // Step 3: stalled rsp channel does not block req; 9th rsp beat overflows
    rsp_ready_i = 1'b0;
    req_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send(1, 64'(32'hC00 + i), 1);
    send(0, 64'hA1, 1);
    send(0, 64'hA2, 1);
    repeat (3) tick();
    chk("t3_no_ovf", overflow_o, 0);
    chk("t3_req_drained", req_valid_o, 0);
    p0 = pops[1];
    send(1, 64'hBAD, 0);
    chk("t3_ovf_set", overflow_o, 1);
    rsp_ready_i = 1'b1;
    repeat (10) tick();
    chk("t3_rsp_drained", rsp_valid_o, 0);
    chk("t3_rsp_count", pops[1] - p0, 8);
    chk("t3_ovf_sticky", overflow_o, 1);

    // Step 4: both channels pending; grants alternate req then rsp
    do_reset();
    credit_ready_i = 1'b0;
    req_ready_i = 1'b1;
    rsp_ready_i = 1'b1;
    send(1, 64'h5, 0);
    repeat (3) tick();
    chk("t4_first_chan", credit_chan_o, 1);
    chk("t4_first_cnt", credit_cnt_o, 1);
    send(0, 64'h1, 0);
    send(0, 64'h2, 0);
    send(1, 64'h3, 0);
    send(1, 64'h4, 0);
    send(1, 64'h5, 0);
    repeat (4) tick();
    credit_ready_i = 1'b1;
    tick();
    chk("t4_req_valid", credit_valid_o, 1);
    chk("t4_req_chan", credit_chan_o, 0);
    chk("t4_req_cnt", credit_cnt_o, 2);
    tick();
    chk("t4_rsp_valid", credit_valid_o, 1);
    chk("t4_rsp_chan", credit_chan_o, 1);
    chk("t4_rsp_cnt", credit_cnt_o, 3);
    tick();
    chk("t4_idle", credit_valid_o, 0);

    // Step 5: reset with flits buffered and a credit on offer
    credit_ready_i = 1'b0;
    send(0, 64'h77, 0);
    repeat (3) tick();
    req_ready_i = 1'b0;
    rsp_ready_i = 1'b0;
    send(0, 64'h1, 0);
    send(0, 64'h2, 0);
    send(1, 64'h3, 0);
    send(1, 64'h4, 0);
    chk("t5_pre_credit", credit_valid_o, 1);
    chk("t5_pre_req", req_valid_o, 1);
    rst_ni = 1'b0;
    tick();
    chk("t5_req_valid", req_valid_o, 0);
    chk("t5_rsp_valid", rsp_valid_o, 0);
    chk("t5_credit_valid", credit_valid_o, 0);
    chk("t5_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    req_ready_i = 1'b1;
    rsp_ready_i = 1'b1;
    credit_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_residual_credit", credit_valid_o, 0);
    end

    // Step 6: random traffic from a credit-obeying transmitter
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      req_ready_i = ($urandom_range(0, 3) != 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      credit_ready_i = ($urandom_range(0, 2) != 0);
      c = 1'($urandom_range(0, 1));
      if (tx_cred[c] > 0 && $urandom_range(0, 3) != 0) begin
        send(c, {$urandom(), $urandom()}, 1);
        sent++;
      end else begin
        tick();
      end
      chk("t6_tx_cred_bound", (tx_cred[0] <= NC) && (tx_cred[1] <= NC), 1);
      cyc++;
    end
    chk("t6_all_sent", sent, 10000);
    req_ready_i = 1'b1;
    rsp_ready_i = 1'b1;
    credit_ready_i = 1'b1;
    repeat (60) tick();
    chk("t6_req_credits", returned[0], pops[0]);
    chk("t6_rsp_credits", returned[1], pops[1]);
    chk("t6_req_empty", q_req.size(), 0);
    chk("t6_rsp_empty", q_rsp.size(), 0);
    chk("t6_no_ovf", overflow_o, 0);
    chk("t6_tx_cred_full", (tx_cred[0] == NC) && (tx_cred[1] == NC), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
